pc_stack_sequencer: RTL and testbench

PC_STACK_SEQUENCER -- requirements
Module: pc_stack_sequencer

---
 rtl/pc_seq_pkg.sv | 29 ++
 rtl/pc_return_stack.sv | 59 +++++
 rtl/pc_stack_sequencer.sv | 95 +++++++++
 tb/tb_pc_stack_sequencer.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/pc_seq_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pc_seq_pkg : action encoding and strobe priority decode for the PC sequencer
// Rev 1.0
// ----------------------------------------------------------------------------
package pc_seq_pkg;

  typedef enum logic [2:0] {
    ACT_HOLD = 3'd0,
    ACT_RET  = 3'd1,
    ACT_CALL = 3'd2,
    ACT_JUMP = 3'd3,
    ACT_INC  = 3'd4
  } action_t;

  // Reset is handled by the registers themselves, so it is not part of the decode.
  function automatic action_t decode_action(input logic stall, input logic ret,
                                            input logic call, input logic jump);
    action_t act;
    if (stall)      act = ACT_HOLD;
    else if (ret)   act = ACT_RET;
    else if (call)  act = ACT_CALL;
    else if (jump)  act = ACT_JUMP;
    else            act = ACT_INC;
    return act;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pc_return_stack.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pc_return_stack : LIFO of return addresses; only the occupancy count is reset
// Rev 1.0
// ----------------------------------------------------------------------------
module pc_return_stack #(
  parameter int ADDR_W      = 16,
  parameter int STACK_DEPTH = 8
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         push,
  input  logic                         pop,
  input  logic [ADDR_W-1:0]            push_data,
  output logic [ADDR_W-1:0]            top,
  output logic [$clog2(STACK_DEPTH):0] depth
);

  localparam int PTR_W = $clog2(STACK_DEPTH);
  localparam logic [PTR_W:0] c_FULL = (PTR_W+1)'(STACK_DEPTH);

  logic [ADDR_W-1:0] r_mem [STACK_DEPTH];
  logic [PTR_W:0]    r_depth;
  logic              w_full;
  logic              w_empty;
  logic              w_do_push;
  logic              w_do_pop;
  logic [PTR_W-1:0]  w_wr_idx;
  logic [PTR_W-1:0]  w_top_idx;

  assign w_full    = (r_depth == c_FULL);
  assign w_empty   = (r_depth == '0);
  assign w_do_pop  = pop && !w_empty && !reset;
  assign w_do_push = push && !pop && !w_full && !reset;
  // With a full stack the low bits wrap to 0, so "minus one" lands on the last slot.
  assign w_wr_idx  = r_depth[PTR_W-1:0];
  assign w_top_idx = r_depth[PTR_W-1:0] - PTR_W'(1);

  always_ff @(posedge clock) begin
    if (reset) begin
      r_depth <= '0;
    end else if (w_do_pop) begin
      r_depth <= r_depth - (PTR_W+1)'(1);
    end else if (w_do_push) begin
      r_depth <= r_depth + (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (w_do_push) begin
      r_mem[w_wr_idx] <= push_data;
    end
  end

  assign top   = r_mem[w_top_idx];
  assign depth = r_depth;

endmodule
`default_nettype wire

// File: rtl/pc_stack_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pc_stack_sequencer : program counter with jump, call/ret return stack
// Rev 1.0
// ----------------------------------------------------------------------------
module pc_stack_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              ADDR_W      = 16,
  parameter int              STACK_DEPTH = 8,
  parameter logic [ADDR_W-1:0] RESET_ADDR = '0,
  parameter bit              JUMP_PLUS1  = 1'b1
) (
  input  logic                         clock,
  input  logic                         reset,
  input  logic                         stall,
  input  logic                         jump,
  input  logic                         call,
  input  logic                         ret,
  input  logic [ADDR_W-1:0]            target,
  output logic [ADDR_W-1:0]            counter,
  output logic [$clog2(STACK_DEPTH):0] depth,
  output logic                         stack_full,
  output logic                         stack_empty,
  output logic                         error
);

  localparam int DEPTH_W = $clog2(STACK_DEPTH) + 1;
  localparam logic [DEPTH_W-1:0] c_FULL = DEPTH_W'(STACK_DEPTH);

  action_t             w_action;
  logic [ADDR_W-1:0]   r_counter;
  logic [ADDR_W-1:0]   w_next_counter;
  logic [ADDR_W-1:0]   w_inc;
  logic [ADDR_W-1:0]   w_top;
  logic [DEPTH_W-1:0]  w_depth;
  logic                r_error;
  logic                w_set_error;
  logic                w_full;
  logic                w_empty;

  assign w_action = decode_action(stall, ret, call, jump);
  assign w_inc    = r_counter + ADDR_W'(1);
  assign w_full   = (w_depth == c_FULL);
  assign w_empty  = (w_depth == '0);

  pc_return_stack #(
    .ADDR_W      (ADDR_W),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_stack (
    .clock     (clock),
    .reset     (reset),
    .push      (w_action == ACT_CALL),
    .pop       (w_action == ACT_RET),
    .push_data (w_inc),
    .top       (w_top),
    .depth     (w_depth)
  );

  always_comb begin
    w_next_counter = r_counter;
    w_set_error    = 1'b0;
    unique case (w_action)
      ACT_RET: begin
        if (w_empty) w_set_error    = 1'b1;
        else         w_next_counter = w_top;
      end
      ACT_CALL: begin
        if (w_full)  w_set_error    = 1'b1;
        else         w_next_counter = target;
      end
      ACT_JUMP: w_next_counter = JUMP_PLUS1 ? (target + ADDR_W'(1)) : target;
      ACT_INC:  w_next_counter = w_inc;
      default:  w_next_counter = r_counter;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_counter <= RESET_ADDR;
      r_error   <= 1'b0;
    end else begin
      r_counter <= w_next_counter;
      r_error   <= r_error | w_set_error;
    end
  end

  assign counter     = r_counter;
  assign depth       = w_depth;
  assign stack_full  = w_full;
  assign stack_empty = w_empty;
  assign error       = r_error;

endmodule
`default_nettype wire

// File: tb/tb_pc_stack_sequencer.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_pc_stack_sequencer : directed checks of counter, stack and error behaviour
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_pc_stack_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        jump  = 1'b0;
  logic        call  = 1'b0;
  logic        ret   = 1'b0;
  logic [15:0] target = '0;

  logic [15:0] counter, counter0;
  logic [3:0]  depth, depth0;
  logic        stack_full, stack_empty, error;
  logic        stack_full0, stack_empty0, error0;

  int tests  = 0;
  int failed = 0;

  always #5 clock = ~clock;

  pc_stack_sequencer #(.ADDR_W(16), .STACK_DEPTH(8), .RESET_ADDR(16'h0000), .JUMP_PLUS1(1'b1)) dut (
    .clock(clock), .reset(reset), .stall(stall), .jump(jump), .call(call), .ret(ret),
    .target(target), .counter(counter), .depth(depth), .stack_full(stack_full),
    .stack_empty(stack_empty), .error(error)
  );

  pc_stack_sequencer #(.ADDR_W(16), .STACK_DEPTH(8), .RESET_ADDR(16'h0000), .JUMP_PLUS1(1'b0)) dut0 (
    .clock(clock), .reset(reset), .stall(stall), .jump(jump), .call(call), .ret(ret),
    .target(target), .counter(counter0), .depth(depth0), .stack_full(stack_full0),
    .stack_empty(stack_empty0), .error(error0)
  );

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic strobes(input logic s, input logic r, input logic c, input logic j, input logic [15:0] t);
    stall = s; ret = r; call = c; jump = j; target = t;
  endtask

  logic [15:0] exp_pc;

  initial begin
    // Reset state
    step();
    check("rst_counter", 32'(counter), 32'h0);
    check("rst_depth", 32'(depth), 32'h0);
    check("rst_empty", 32'(stack_empty), 32'h1);
    check("rst_full", 32'(stack_full), 32'h0);
    check("rst_error", 32'(error), 32'h0);
    check("rst_dut0", {counter0, 12'h0, depth0, stack_full0, stack_empty0, error0, 1'b0}, 32'h0000_0004);
    reset = 1'b0;

    // Idle increments
    for (int i = 1; i <= 3; i++) begin
      step();
      check("idle_inc", 32'(counter), 32'(i));
    end

    // Jump, both JUMP_PLUS1 settings
    strobes(0, 0, 0, 1, 16'h0020);
    step();
    check("jump_plus1", 32'(counter), 32'h0021);
    check("jump_exact", 32'(counter0), 32'h0020);
    strobes(0, 0, 0, 1, 16'h000F);
    step();
    check("jump_to_10", 32'(counter), 32'h0010);

    // Call / ret round trip
    strobes(0, 0, 1, 0, 16'h0100);
    step();
    check("call_pc", 32'(counter), 32'h0100);
    check("call_depth", 32'(depth), 32'h1);
    check("call_not_empty", 32'(stack_empty), 32'h0);
    strobes(0, 1, 0, 0, 16'h0000);
    step();
    check("ret_pc", 32'(counter), 32'h0011);
    check("ret_depth", 32'(depth), 32'h0);

    // ret+call: only ret runs
    strobes(0, 0, 1, 0, 16'h0200);
    step();
    check("call2_pc", 32'(counter), 32'h0200);
    strobes(0, 1, 1, 0, 16'h0300);
    step();
    check("retcall_pc", 32'(counter), 32'h0012);
    check("retcall_depth", 32'(depth), 32'h0);
    check("retcall_err", 32'(error), 32'h0);

    // call+jump: call wins, loads target exactly
    strobes(0, 0, 1, 1, 16'h0040);
    step();
    check("calljump_pc", 32'(counter), 32'h0040);
    check("calljump_depth", 32'(depth), 32'h1);
    strobes(0, 1, 0, 0, 16'h0000);
    step();
    check("calljump_ret", 32'(counter), 32'h0013);

    // Fill stack: pushes 0x14, then 0x1001, 0x1101, ..., 0x1601
    for (int i = 0; i < 8; i++) begin
      strobes(0, 0, 1, 0, 16'h1000 + 16'(i * 16'h100));
      step();
      check("fill_pc", 32'(counter), 32'h1000 + 32'(i * 32'h100));
      check("fill_depth", 32'(depth), 32'(i + 1));
    end
    check("fill_full", 32'(stack_full), 32'h1);
    check("fill_err", 32'(error), 32'h0);
    strobes(0, 0, 1, 0, 16'h2000);
    step();
    check("ovf_pc", 32'(counter), 32'h1700);
    check("ovf_depth", 32'(depth), 32'h8);
    check("ovf_err", 32'(error), 32'h1);

    // Unwind LIFO
    for (int k = 0; k < 8; k++) begin
      strobes(0, 1, 0, 0, 16'h0000);
      step();
      exp_pc = (k == 7) ? 16'h0014 : (16'h1001 + 16'((6 - k) * 16'h100));
      check("unwind_pc", 32'(counter), 32'(exp_pc));
      check("unwind_depth", 32'(depth), 32'(7 - k));
    end
    step();
    check("udf_pc", 32'(counter), 32'h0014);
    check("udf_err", 32'(error), 32'h1);
    check("udf_empty", 32'(stack_empty), 32'h1);
    strobes(0, 0, 0, 0, 16'h0000);
    step();
    check("err_sticky", 32'(error), 32'h1);
    check("err_sticky_pc", 32'(counter), 32'h0015);

    // Wrap and stall
    strobes(0, 0, 0, 1, 16'hFFFE);
    step();
    check("wrap_pre", 32'(counter), 32'hFFFF);
    strobes(0, 0, 0, 0, 16'h0000);
    step();
    check("wrap", 32'(counter), 32'h0000);
    strobes(1, 0, 1, 0, 16'h0500);
    step();
    check("stall_pc", 32'(counter), 32'h0000);
    check("stall_depth", 32'(depth), 32'h0);
    strobes(1, 1, 0, 0, 16'h0000);
    step();
    check("stall_ret_pc", 32'(counter), 32'h0000);

    // Build depth 5, then reset together with call
    for (int i = 0; i < 5; i++) begin
      strobes(0, 0, 1, 0, 16'h0800);
      step();
    end
    check("pre_rst_depth", 32'(depth), 32'h5);
    check("pre_rst_err", 32'(error), 32'h1);
    reset = 1'b1;
    strobes(0, 0, 1, 0, 16'h0900);
    step();
    check("mid_rst_pc", 32'(counter), 32'h0000);
    check("mid_rst_depth", 32'(depth), 32'h0);
    check("mid_rst_err", 32'(error), 32'h0);
    check("mid_rst_empty", 32'(stack_empty), 32'h1);
    reset = 1'b0;
    strobes(0, 1, 0, 0, 16'h0000);
    step();
    check("post_rst_udf_pc", 32'(counter), 32'h0000);
    check("post_rst_udf_err", 32'(error), 32'h1);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
`default_nettype wire
